// File: rtl/mem_csr_unit.sv
// Machine-mode CSR file and interrupt/MRET sequencer for the MEM stage.
// Optional build macro: MTVEC_VECTORED_EN enables vectored interrupt dispatch via mtvec[1:0].
module mem_csr_unit #(
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] HART_ID      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mvalid,
  input  logic        mem_csr_en,
  input  logic [2:0]  mfunc3,
  input  logic [11:0] mem_csr_addr,
  input  logic [31:0] csr_wdata_mem,
  input  logic        is_mret_mem,
  input  logic [31:0] mpc,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_CYCLES);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic        st_mie, st_mpie, ie_meie, ie_mtie;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle_q, mcycle_inc;

  logic        known, pending, irq_ext, take_trap, take_mret, wr_en;
  logic [31:0] wval, trap_cause, trap_vec, mtvec_wval;
  logic [2:0]  unused_bits;

  // imm-form bit is handled identically; mepc low bits are always zero
  assign unused_bits = {mfunc3[2], mpc[1:0]};

  always_comb begin
    csr_rdata = '0;
    known     = 1'b1;
    case (mem_csr_addr)
      12'h300: csr_rdata = {24'h0, st_mpie, 3'b000, st_mie, 3'b000};
      12'h304: csr_rdata = {20'h0, ie_meie, 3'b000, ie_mtie, 7'h00};
      12'h305: csr_rdata = mtvec_q;
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h344: csr_rdata = {20'h0, ext_irq, 3'b000, timer_irq, 7'h00};
      12'hB00: csr_rdata = mcycle_q[31:0];
      12'hB80: csr_rdata = mcycle_q[63:32];
      12'hF14: csr_rdata = HART_ID;
      default: known = 1'b0;
    endcase
  end

  assign csr_illegal = mem_csr_en & mvalid & ~known;

  always_comb begin
    case (mfunc3[1:0])
      2'b01:   wval = csr_wdata_mem;
      2'b10:   wval = csr_rdata | csr_wdata_mem;
      2'b11:   wval = csr_rdata & ~csr_wdata_mem;
      default: wval = csr_rdata;
    endcase
  end

  assign irq_ext    = ext_irq & ie_meie;
  assign pending    = mvalid & st_mie & (irq_ext | (timer_irq & ie_mtie));
  assign take_trap  = (state == S_IDLE) & pending;
  assign take_mret  = (state == S_IDLE) & ~pending & mvalid & is_mret_mem;
  assign wr_en      = mvalid & mem_csr_en & (state == S_IDLE) & ~take_trap &
                      (mfunc3[1:0] != 2'b00);
  assign trap_cause = irq_ext ? 32'h8000_000B : 32'h8000_0007;
  assign mcycle_inc = mcycle_q + 64'd1;

`ifdef MTVEC_VECTORED_EN
  assign trap_vec   = (mtvec_q[1:0] == 2'b01) ?
                      {mtvec_q[31:2], 2'b00} + {26'h0, trap_cause[3:0], 2'b00} :
                      {mtvec_q[31:2], 2'b00};
  assign mtvec_wval = {wval[31:2], (wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
  assign trap_vec   = {mtvec_q[31:2], 2'b00};
  assign mtvec_wval = {wval[31:2], 2'b00};
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (take_trap || take_mret) state_nx = S_FLUSH;
      S_FLUSH: if (cnt == CNT_LAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= (state == S_FLUSH && state_nx == S_FLUSH) ? cnt + 1'b1 : '0;
      redirect <= take_trap | take_mret;
      if (take_trap)      redirect_pc <= trap_vec;
      else if (take_mret) redirect_pc <= mepc_q;
    end
  end

  assign flush = (state == S_FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      ie_meie    <= 1'b0;
      ie_mtie    <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
    end else begin
      // a write to either half replaces that half; the other still takes the increment/carry
      mcycle_q[31:0]  <= (wr_en && mem_csr_addr == 12'hB00) ? wval : mcycle_inc[31:0];
      mcycle_q[63:32] <= (wr_en && mem_csr_addr == 12'hB80) ? wval : mcycle_inc[63:32];
      if (wr_en) begin
        case (mem_csr_addr)
          12'h300: begin st_mie <= wval[3]; st_mpie <= wval[7]; end
          12'h304: begin ie_meie <= wval[11]; ie_mtie <= wval[7]; end
          12'h305: mtvec_q    <= mtvec_wval;
          12'h340: mscratch_q <= wval;
          12'h341: mepc_q     <= {wval[31:2], 2'b00};
          12'h342: mcause_q   <= wval;
          default: ;
        endcase
      end
      if (take_trap) begin
        mepc_q   <= {mpc[31:2], 2'b00};
        mcause_q <= trap_cause;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (take_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_csr_unit.sv
// Directed self-checking bench for mem_csr_unit (default build, FLUSH_CYCLES=2).
module tb_mem_csr_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mvalid, mem_csr_en, is_mret_mem, ext_irq, timer_irq;
  logic [2:0]  mfunc3;
  logic [11:0] mem_csr_addr;
  logic [31:0] csr_wdata_mem, mpc;
  logic [31:0] csr_rdata, redirect_pc;
  logic        csr_illegal, redirect, flush;

  int total = 0;
  int bad   = 0;
  int n;

  mem_csr_unit #(.MTVEC_RESET(32'h0000_0000), .FLUSH_CYCLES(2), .HART_ID(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .mvalid(mvalid), .mem_csr_en(mem_csr_en), .mfunc3(mfunc3),
    .mem_csr_addr(mem_csr_addr), .csr_wdata_mem(csr_wdata_mem), .is_mret_mem(is_mret_mem),
    .mpc(mpc), .ext_irq(ext_irq), .timer_irq(timer_irq), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mvalid = 1'b0; mem_csr_en = 1'b0; is_mret_mem = 1'b0; mfunc3 = 3'b000;
  endtask

  task automatic csr_op(input logic [2:0] f, input logic [11:0] a, input logic [31:0] wd,
                        input bit chk, input logic [31:0] exp, input string tag);
    mvalid = 1'b1; mem_csr_en = 1'b1; mfunc3 = f; mem_csr_addr = a; csr_wdata_mem = wd;
    #1;
    if (chk) check(tag, csr_rdata, exp);
    tick();
    idle_in();
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    csr_op(3'b000, a, 32'h0, 1'b1, exp, tag);
  endtask

  task automatic wait_flush_done();
    for (int i = 0; i < 20; i++) begin
      if (!flush) break;
      tick();
    end
    check("flush_timeout", {31'h0, flush}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idle_in(); ext_irq = 1'b0; timer_irq = 1'b0;
    mem_csr_addr = '0; csr_wdata_mem = '0; mpc = '0;
    tick(); tick();
    check("rst_flush", {31'h0, flush}, 32'h0);
    check("rst_redirect", {31'h0, redirect}, 32'h0);
    check("rst_rpc", redirect_pc, 32'h0);
    rst = 1'b0;
    rd(12'h300, 32'h0, "rst_mstatus");
    rd(12'h305, 32'h0, "rst_mtvec");

    // 1: RW then RS on mtvec
    csr_op(3'b001, 12'h305, 32'h8000_0100, 1'b1, 32'h0, "t1_rw_old");
    csr_op(3'b010, 12'h305, 32'h0000_0003, 1'b1, 32'h8000_0100, "t1_rs_old");
    rd(12'h305, 32'h8000_0100, "t1_mtvec");

    // 2: external interrupt trap
    csr_op(3'b010, 12'h300, 32'h8, 1'b0, 32'h0, "");
    csr_op(3'b010, 12'h304, 32'h800, 1'b0, 32'h0, "");
    mpc = 32'h200; mvalid = 1'b1; ext_irq = 1'b1;
    tick();
    check("t2_redirect", {31'h0, redirect}, 32'h1);
    check("t2_rpc", redirect_pc, 32'h8000_0100);
    check("t2_flush", {31'h0, flush}, 32'h1);
    mvalid = 1'b0; ext_irq = 1'b0;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) check("t2_pulse", {31'h0, redirect}, 32'h0);
      if (!flush) break;
      n++;
    end
    check("t2_flush_len", n, 32'd3);
    rd(12'h341, 32'h200, "t2_mepc");
    rd(12'h342, 32'h8000_000B, "t2_mcause");
    rd(12'h300, 32'h80, "t2_mstatus");

    // 3: MRET, then no re-trap and no CSR write during flush
    csr_op(3'b001, 12'h341, 32'h204, 1'b0, 32'h0, "");
    mvalid = 1'b1; is_mret_mem = 1'b1; ext_irq = 1'b1;
    tick();
    check("t3_redirect", {31'h0, redirect}, 32'h1);
    check("t3_rpc", redirect_pc, 32'h204);
    check("t3_flush", {31'h0, flush}, 32'h1);
    is_mret_mem = 1'b0;
    mem_csr_en = 1'b1; mfunc3 = 3'b001; mem_csr_addr = 12'h340; csr_wdata_mem = 32'hDEAD_BEEF;
    tick();
    check("t3_noretrap1", {30'h0, redirect, flush}, 32'h1);
    mem_csr_en = 1'b0;
    tick();
    check("t3_noretrap2", {30'h0, redirect, flush}, 32'h1);
    mvalid = 1'b0; ext_irq = 1'b0;
    tick();
    check("t3_flush_end", {30'h0, redirect, flush}, 32'h0);
    rd(12'h300, 32'h88, "t3_mstatus");
    rd(12'h340, 32'h0, "t3_mscratch");

    // 4: both pending with CSRRW mscratch in MEM
    csr_op(3'b010, 12'h304, 32'h80, 1'b1, 32'h800, "t4_mie_old");
    mpc = 32'h300; mvalid = 1'b1; ext_irq = 1'b1; timer_irq = 1'b1;
    mem_csr_en = 1'b1; mfunc3 = 3'b001; mem_csr_addr = 12'h340; csr_wdata_mem = 32'h1234;
    tick();
    check("t4_redirect", {31'h0, redirect}, 32'h1);
    idle_in(); ext_irq = 1'b0; timer_irq = 1'b0;
    wait_flush_done();
    rd(12'h342, 32'h8000_000B, "t4_mcause");
    rd(12'h340, 32'h0, "t4_mscratch");
    rd(12'h341, 32'h300, "t4_mepc");
    rd(12'h300, 32'h80, "t4_mstatus");

    // 5: mcycle carry, RO/unknown addresses
    csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'h0, "");
    rd(12'hB00, 32'hFFFF_FFFF, "t5_lo_written");
    rd(12'hB00, 32'h0, "t5_lo_wrapped");
    rd(12'hB80, 32'h1, "t5_hi_carry");
    rd(12'hF14, 32'h0, "t5_hartid");
    check("t5_legal", {31'h0, csr_illegal}, 32'h0);
    ext_irq = 1'b1;
    rd(12'h344, 32'h800, "t5_mip");
    ext_irq = 1'b0;
    mvalid = 1'b1; mem_csr_en = 1'b1; mfunc3 = 3'b001; mem_csr_addr = 12'h7C0;
    #1;
    check("t5_unk_rdata", csr_rdata, 32'h0);
    check("t5_illegal", {31'h0, csr_illegal}, 32'h1);
    tick();
    idle_in();

    // 6: reset during flush
    mvalid = 1'b1; is_mret_mem = 1'b1;
    tick();
    check("t6_flush", {31'h0, flush}, 32'h1);
    idle_in(); rst = 1'b1;
    tick();
    check("t6_flush_rst", {31'h0, flush}, 32'h0);
    check("t6_redirect_rst", {31'h0, redirect}, 32'h0);
    check("t6_rpc_rst", redirect_pc, 32'h0);
    rst = 1'b0;
    rd(12'h300, 32'h0, "t6_mstatus");
    rd(12'h305, 32'h0, "t6_mtvec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
